// File: rtl/eth_axis_frame_gen.sv
`timescale 1ns/1ps
// Purpose: Ethernet test-frame generator, AXI-Stream master feeding the 10G MAC TX port.
// Latency: first beat is valid the cycle after i_start is sampled; GAP_CYCLES idle cycles between frames.
// Backpressure: beats advance only on tvalid&&tready; outputs hold steady while tready is low.
//
// Ports:
//   i_tx_clk, i_tx_reset         TX clock, synchronous active-high reset
//   i_start, i_stop              run start pulse / stop request (honoured at a frame boundary)
//   i_payload_len, i_n_frames    payload bytes (clamped 46..1500), frames per run (0 = endless)
//   m_axis_t*                    AXI-Stream master; symbol 0 of tdata is the first byte on the wire
//   o_busy, o_frame_cnt, o_done  run status, completed-frame count, end-of-run pulse
module eth_axis_frame_gen #(
    parameter int          N_SYMBOLS  = 8,
    parameter int          W_SYMBOL   = 8,
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          GAP_CYCLES = 2
) (
    input  logic                          i_tx_clk,
    input  logic                          i_tx_reset,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic [10:0]                   i_payload_len,
    input  logic [15:0]                   i_n_frames,
    output logic                          m_axis_tvalid,
    output logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
    output logic [N_SYMBOLS-1:0]          m_axis_tkeep,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          o_busy,
    output logic [15:0]                   o_frame_cnt,
    output logic                          o_done
);

    localparam int HDR_LEN = 14;
    localparam logic [8*HDR_LEN-1:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  beat_q;
    logic [10:0] len_q;      // total frame length in bytes, header included
    logic [7:0]  seed_q;
    logic [15:0] cnt_q;
    logic [15:0] nfr_q;
    logic        stop_q;
    logic [7:0]  gap_q;
    logic        done_q;

    logic [10:0] pay_len;
    logic [10:0] frame_len;
    logic [7:0]  last_beat;
    logic        is_last;
    logic        hs;
    logic        hs_last;
    logic [15:0] cnt_inc;
    logic        end_run;
    logic        load;
    logic [7:0]  seed_d;
    logic [10:0] byte_idx;

    // Header bytes come straight from the constant; payload is a running byte from the seed.
    function automatic logic [W_SYMBOL-1:0] frame_byte(input logic [10:0] b, input logic [7:0] seed);
        logic [7:0] v;
        if (b < 11'(HDR_LEN)) v = HDR[8*(HDR_LEN-1-int'(b)) +: 8];
        else                  v = seed + b[7:0] - 8'(HDR_LEN);
        return W_SYMBOL'(v);
    endfunction

    always_comb begin
        if (i_payload_len < 11'd46)        pay_len = 11'd46;
        else if (i_payload_len > 11'd1500) pay_len = 11'd1500;
        else                               pay_len = i_payload_len;
    end

    assign frame_len = pay_len + 11'(HDR_LEN);
    assign last_beat = 8'((len_q - 11'd1) / 11'(N_SYMBOLS));
    assign is_last   = (beat_q == last_beat);
    assign hs        = (state_q == S_FRAME) && m_axis_tready;
    assign hs_last   = hs && is_last;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // A stop arriving in the very cycle of the tlast handshake still ends the run there.
    assign end_run   = stop_q || i_stop || ((nfr_q != 16'd0) && (cnt_inc == nfr_q));
    // New frame parameters are captured whenever FRAME is (re)entered, including back-to-back frames.
    assign load      = (state_d == S_FRAME) && ((state_q != S_FRAME) || hs_last);

    // State register
    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_FRAME;
            S_FRAME: begin
                if (hs_last) begin
                    if (end_run)              state_d = S_IDLE;
                    else if (GAP_CYCLES == 0) state_d = S_FRAME;
                    else                      state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (stop_q || i_stop)   state_d = S_IDLE;
                else if (gap_q == 8'd0) state_d = S_FRAME;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Seed for the frame being loaded: the count of frames already finished in this run.
    always_comb begin
        case (state_q)
            S_GAP:   seed_d = cnt_q[7:0];
            S_FRAME: seed_d = cnt_inc[7:0];
            default: seed_d = 8'd0;
        endcase
    end

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            beat_q <= '0;
            len_q  <= '0;
            seed_q <= '0;
            cnt_q  <= '0;
            nfr_q  <= '0;
            stop_q <= 1'b0;
            gap_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q != S_IDLE) && (state_d == S_IDLE);
            if (state_q == S_IDLE) begin
                // A stop in IDLE is dropped unless it coincides with a start.
                stop_q <= i_start && i_stop;
                if (i_start) begin
                    cnt_q <= '0;
                    nfr_q <= i_n_frames;
                end
            end else begin
                if (i_stop)  stop_q <= 1'b1;
                if (hs_last) cnt_q  <= cnt_inc;
            end
            if (load) begin
                beat_q <= '0;
                len_q  <= frame_len;
                seed_q <= seed_d;
            end else if (hs) begin
                beat_q <= beat_q + 8'd1;
            end
            if (state_q == S_FRAME && state_d == S_GAP)
                gap_q <= 8'(GAP_CYCLES - 1);
            else if (state_q == S_GAP && gap_q != 8'd0)
                gap_q <= gap_q - 8'd1;
        end
    end

    // Outputs: everything is derived from registered state, so it cannot change during a stall.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tdata  = '0;
        o_busy        = (state_q != S_IDLE);
        byte_idx      = '0;
        if (state_q == S_FRAME) begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = is_last;
            for (int k = 0; k < N_SYMBOLS; k++) begin
                byte_idx = 11'(beat_q) * 11'(N_SYMBOLS) + 11'(k);
                // Lanes past the end of the frame stay zero with keep low.
                if (byte_idx < len_q) begin
                    m_axis_tkeep[k]                         = 1'b1;
                    m_axis_tdata[k*W_SYMBOL +: W_SYMBOL]    = frame_byte(byte_idx, seed_q);
                end
            end
        end
    end

    assign o_frame_cnt = cnt_q;
    assign o_done      = done_q;

endmodule
